// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED frame buffer scanner.
// Holds the FSM state enum, panel command bytes and default geometry.
package oled_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_PAGE,
        S_CMD_COL_LO,
        S_CMD_COL_HI,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_FRAME_END
    } state_t;

    localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO   = 8'h00;
    localparam logic [7:0] CMD_COL_HI   = 8'h10;

    localparam int OLED_PAGES = 8;
    localparam int OLED_COLS  = 128;

endpackage

// File: rtl/oled_fb_scanner.sv
// Scans the frame buffer RAM out to the SPI OLED byte transmitter:
// per page, three addressing command bytes then COLS data bytes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse, begins a frame when idle
//   continuous        sampled at frame end, 1 = rescan immediately
//   busy              high from accepted start until the frame ends
//   frame_done        one-cycle pulse after the last data byte
//   ram_read_addr     RAM read address (this block owns the port)
//   ram_read_data     registered RAM data, valid 1 cycle after addr
//   tx_valid/tx_ready byte handshake to the transmitter
//   tx_data, tx_dc    byte and D/C flag (0 = command, 1 = data)
module oled_fb_scanner
    import oled_pkg::*;
#(
    parameter int PAGES      = OLED_PAGES,
    parameter int COLS       = OLED_COLS,
    parameter int COL_OFFSET = 0,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [7:0]        ram_read_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_dc
);

    localparam logic [7:0]        COL_OFF8  = 8'(COL_OFFSET);
    localparam logic [7:0]        PAGE_LAST = 8'(PAGES - 1);
    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

    state_t            state;
    logic [7:0]        page;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] page_base;
    logic              xfer;

    assign page_base = ADDR_W'(page) * COLS_A;
    assign xfer      = tx_valid && tx_ready;

    // The read address is loaded on the edge that enters FETCH, so
    // the RAM registers it at FETCH->WAIT and the byte is stable
    // during WAIT, where it is captured on the WAIT->SEND edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            page          <= '0;
            col           <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            ram_read_addr <= '0;
            tx_valid      <= 1'b0;
            tx_data       <= 8'h00;
            tx_dc         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CMD_PAGE;
                        busy     <= 1'b1;
                        page     <= '0;
                        col      <= '0;
                        tx_valid <= 1'b1;
                        tx_dc    <= 1'b0;
                        tx_data  <= CMD_SET_PAGE;
                    end
                end
                S_CMD_PAGE: begin
                    if (xfer) begin
                        state   <= S_CMD_COL_LO;
                        tx_data <= CMD_COL_LO | {4'h0, COL_OFF8[3:0]};
                    end
                end
                S_CMD_COL_LO: begin
                    if (xfer) begin
                        state   <= S_CMD_COL_HI;
                        tx_data <= CMD_COL_HI | {4'h0, COL_OFF8[7:4]};
                    end
                end
                S_CMD_COL_HI: begin
                    if (xfer) begin
                        state         <= S_FETCH;
                        col           <= '0;
                        tx_valid      <= 1'b0;
                        ram_read_addr <= page_base;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Only load point of the presented data byte.
                    state    <= S_SEND;
                    tx_data  <= ram_read_data;
                    tx_dc    <= 1'b1;
                    tx_valid <= 1'b1;
                end
                S_SEND: begin
                    if (xfer) begin
                        if (col != COL_LAST) begin
                            state         <= S_FETCH;
                            col           <= col + ADDR_W'(1);
                            ram_read_addr <= page_base + col + ADDR_W'(1);
                            tx_valid      <= 1'b0;
                        end else if (page != PAGE_LAST) begin
                            // tx_valid stays high into the next command.
                            state   <= S_CMD_PAGE;
                            page    <= page + 8'd1;
                            tx_dc   <= 1'b0;
                            tx_data <= CMD_SET_PAGE | (page + 8'd1);
                        end else begin
                            state      <= S_FRAME_END;
                            tx_valid   <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                S_FRAME_END: begin
                    if (continuous) begin
                        state    <= S_CMD_PAGE;
                        page     <= '0;
                        tx_valid <= 1'b1;
                        tx_dc    <= 1'b0;
                        tx_data  <= CMD_SET_PAGE;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_fb_scanner.sv
// Directed testbench for oled_fb_scanner: one default instance and
// one with COL_OFFSET=2 sharing clock, reset and handshake inputs.
module tb_oled_fb_scanner;

    localparam int FRAME_N = 1048;

    logic       clk;
    logic       rst;
    logic       start;
    logic       continuous;
    logic       tx_ready;

    logic       busy, frame_done, tx_valid, tx_dc;
    logic [9:0] ram_read_addr;
    logic [7:0] ram_read_data, tx_data;

    logic       busy2, frame_done2, tx_valid2, tx_dc2;
    logic [9:0] ram_read_addr2;
    logic [7:0] ram_read_data2, tx_data2;

    logic [7:0] mem [0:1023];

    logic [8:0] cap1 [0:FRAME_N+49];
    logic [8:0] cap2 [0:FRAME_N+49];
    int         cap_n;
    int         stall_err;
    bit         busy_low;

    int n_chk;
    int n_fail;

    oled_fb_scanner dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .continuous    (continuous),
        .busy          (busy),
        .frame_done    (frame_done),
        .ram_read_addr (ram_read_addr),
        .ram_read_data (ram_read_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_dc         (tx_dc)
    );

    oled_fb_scanner #(.COL_OFFSET(2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .continuous    (continuous),
        .busy          (busy2),
        .frame_done    (frame_done2),
        .ram_read_addr (ram_read_addr2),
        .ram_read_data (ram_read_data2),
        .tx_valid      (tx_valid2),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data2),
        .tx_dc         (tx_dc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM models, one read port per instance.
    always @(posedge clk) begin
        ram_read_data  <= mem[ram_read_addr];
        ram_read_data2 <= mem[ram_read_addr2];
    end

    function automatic logic [8:0] exp_byte(input int k, input int off);
        int pg;
        int r;
        pg = k / 131;
        r  = k % 131;
        if (r == 0) return {1'b0, 8'hB0 | 8'(pg)};
        if (r == 1) return {1'b0, 8'(off & 15)};
        if (r == 2) return {1'b0, 8'h10 | 8'(off >> 4)};
        return {1'b1, 8'((pg * 128 + r - 3) & 255)};
    endfunction

    // Records accepted bytes from both instances, starting at the
    // current negedge. Stops at frame_done, or after stop_n bytes.
    // At cycle evt_at it pulses start and clears continuous.
    task automatic capture(input bit rnd, input int stop_n,
                           input int evt_at, output bit timeout);
        bit         held;
        logic [8:0] hv;
        cap_n     = 0;
        stall_err = 0;
        busy_low  = 1'b0;
        timeout   = 1'b1;
        held      = 1'b0;
        hv        = '0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (held && (tx_valid !== 1'b1 || {tx_dc, tx_data} !== hv))
                stall_err++;
            if (busy !== 1'b1) busy_low = 1'b1;
            if (frame_done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            start = (cyc == evt_at);
            if (cyc == evt_at) continuous = 1'b0;
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready && cap_n < FRAME_N + 50)
                cap1[cap_n] = {tx_dc, tx_data};
            if (tx_valid2 && tx_ready && cap_n < FRAME_N + 50)
                cap2[cap_n] = {tx_dc2, tx_data2};
            if (tx_valid && tx_ready) cap_n++;
            held = tx_valid && !tx_ready;
            hv   = {tx_dc, tx_data};
            if (stop_n > 0 && cap_n >= stop_n) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic pulse_start();
        tx_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, frame_done, tx_valid, tx_dc} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {busy, frame_done, tx_valid, tx_dc});
        end
        n_chk++;
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 00", tx_data);
        end
        n_chk++;
        if (ram_read_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d want 0", ram_read_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || busy !== 1'b0 ||
                ram_read_addr !== 10'd0) bad++;
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic check_frame(input string tag, input bit to);
        n_chk++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: got timeout want frame_done", tag);
        end
        n_chk++;
        if (cap_n !== FRAME_N) begin
            n_fail++;
            $display("FAIL %s_count: got %0d want %0d", tag, cap_n, FRAME_N);
        end
        for (int k = 0; k < FRAME_N; k++) begin
            n_chk++;
            if (cap1[k] !== exp_byte(k, 0)) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got %h want %h",
                         tag, k, cap1[k], exp_byte(k, 0));
            end
        end
    endtask

    task automatic test_frame();
        bit to;
        pulse_start();
        capture(1'b0, 0, -1, to);
        check_frame("frame", to);
        n_chk++;
        if (cap1[FRAME_N-1] !== 9'h1FF) begin
            n_fail++;
            $display("FAIL last_byte: got %h want 1ff", cap1[FRAME_N-1]);
        end
        @(negedge clk);
        n_chk++;
        if ({frame_done, busy, tx_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL frame_end_flags: got %b want 000",
                     {frame_done, busy, tx_valid});
        end
    endtask

    task automatic test_col_offset();
        for (int k = 0; k < FRAME_N; k++) begin
            n_chk++;
            if (cap2[k] !== exp_byte(k, 2)) begin
                n_fail++;
                $display("FAIL offset_byte%0d: got %h want %h",
                         k, cap2[k], exp_byte(k, 2));
            end
        end
    endtask

    task automatic test_random_ready();
        bit to;
        pulse_start();
        capture(1'b1, 0, -1, to);
        check_frame("rand", to);
        n_chk++;
        if (stall_err !== 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d violations want 0",
                     stall_err);
        end
        @(negedge clk);
    endtask

    task automatic test_continuous();
        bit to;
        continuous = 1'b1;
        pulse_start();
        capture(1'b0, 0, -1, to);
        check_frame("cont1", to);
        n_chk++;
        if (busy_low !== 1'b0) begin
            n_fail++;
            $display("FAIL cont1_busy: got drop want steady");
        end
        @(negedge clk);
        n_chk++;
        if ({busy, tx_valid, tx_dc, tx_data} !== {3'b110, 8'hB0}) begin
            n_fail++;
            $display("FAIL cont_restart: got %b %h want 110 b0",
                     {busy, tx_valid, tx_dc}, tx_data);
        end
        capture(1'b0, 0, 200, to);
        check_frame("cont2", to);
        n_chk++;
        if (busy_low !== 1'b0) begin
            n_fail++;
            $display("FAIL cont2_busy: got drop want steady");
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if ({busy, tx_valid, frame_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_flags: got %b want 000",
                     {busy, tx_valid, frame_done});
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, tx_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_at_done: got %b want 00", {busy, tx_valid});
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit seen;
        pulse_start();
        capture(1'b0, 3 * 131 + 13, -1, to);
        n_chk++;
        if (to !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reach: got to=%b busy=%b want 0 1", to, busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_chk++;
        if (seen !== 1'b1 || tx_dc !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_valid: got %b%b want 11", seen, tx_dc);
        end
        tx_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if ({tx_valid, busy} !== 2'b00 || ram_read_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b addr %0d want 00 addr 0",
                     {tx_valid, busy}, ram_read_addr);
        end
        pulse_start();
        capture(1'b0, 0, -1, to);
        check_frame("rerun", to);
        @(negedge clk);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        tx_ready   = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = 8'(a);

        test_reset();
        test_idle();
        test_frame();
        test_col_offset();
        test_random_ready();
        test_continuous();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_fb_scanner.md
Name: oled_fb_scanner

Overview:
- Sequences the 1024-byte frame buffer RAM (8 pages x 128 columns, byte address = page*128 + column) out to the SPI OLED byte transmitter.
- Per page, emits the page/column addressing command bytes, then streams the 128 data bytes read from the RAM.
- Sole owner of the RAM read port; sits between myram and the SPI byte-level transmitter.

Parameters:
- PAGES, 8, number of display pages scanned per frame
- COLS, 128, data bytes per page
- COL_OFFSET, 0, panel column start (e.g. 2 for SH1106); drives the column command bytes
- ADDR_W, 10, RAM address width; must satisfy 2**ADDR_W >= PAGES*COLS

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame scan when idle
- continuous  in  1  sampled at frame end; 1 = immediately start the next frame
- busy  out  1  high from accepted start until the frame ends with no restart
- frame_done  out  1  one-cycle pulse after the last data byte of a frame is accepted
- ram_read_addr  out  ADDR_W  RAM read address
- ram_read_data  in  8  RAM read data; registered, valid 1 cycle after ram_read_addr
- tx_valid  out  1  byte available to transmitter
- tx_ready  in  1  transmitter accepts byte
- tx_data  out  8  byte to send
- tx_dc  out  1  0 = command byte, 1 = display data byte

Behaviour:
- Reset: synchronous, active-high.
  - All outputs 0: busy, frame_done, tx_valid, tx_dc, tx_data = 8'h00, ram_read_addr = 0.
  - State returns to IDLE; page and column counters cleared.
  - Reset mid-frame drops tx_valid in the same edge; there is no partial-frame resume.
- Handshake:
  - A transfer occurs on a rising edge where tx_valid && tx_ready.
  - Once tx_valid is high, tx_data and tx_dc hold stable until that transfer.
  - tx_valid is never withdrawn without a transfer, except on reset.
  - tx_ready may be high while tx_valid is low (no effect).
- States:
  - IDLE: start=1 -> CMD_PAGE, busy<=1, page<=0. Start while busy is ignored.
  - CMD_PAGE: tx_data = 8'hB0 | page, tx_dc=0. On transfer -> CMD_COL_LO.
  - CMD_COL_LO: tx_data = 8'h00 | COL_OFFSET[3:0], tx_dc=0. On transfer -> CMD_COL_HI.
  - CMD_COL_HI: tx_data = 8'h10 | COL_OFFSET[7:4], tx_dc=0. On transfer -> FETCH, col<=0.
  - FETCH: ram_read_addr <= page*COLS + col, tx_valid=0. Next cycle -> WAIT.
  - WAIT: one cycle for RAM latency -> SEND.
  - SEND: tx_data <= ram_read_data (captured on entry), tx_dc=1, tx_valid=1.
    - On transfer with col < COLS-1: col++ -> FETCH.
    - On transfer with col = COLS-1 and page < PAGES-1: page++ -> CMD_PAGE.
    - On transfer with col = COLS-1 and page = PAGES-1: -> FRAME_END.
  - FRAME_END: frame_done=1 for exactly one cycle.
    - continuous=1: page<=0 -> CMD_PAGE, busy stays 1.
    - else: -> IDLE, busy<=0 on the same edge.
- Captured data register is loaded only on WAIT->SEND, so RAM writes during a stall cannot change a presented byte.
- Address arithmetic in ADDR_W bits with no wrap; the maximum address is PAGES*COLS-1 (1023 at defaults).
- Throughput: at most one data byte per 3 cycles with tx_ready held high. This is acceptable because SPI serialisation takes >= 8 cycles per byte.
- frame_done and start in the same cycle: start is ignored (block is still busy).

Decomposition:
- Package oled_pkg holds:
  - state enum (IDLE, CMD_PAGE, CMD_COL_LO, CMD_COL_HI, FETCH, WAIT, SEND, FRAME_END);
  - command constants CMD_SET_PAGE = 8'hB0, CMD_COL_LO = 8'h00, CMD_COL_HI = 8'h10;
  - default geometry OLED_PAGES = 8, OLED_COLS = 128.
- No sub-module needed. The single FSM plus counters fit one module (~180 lines).

Test Plan:
- Reset then idle, with tx_ready=1 and no start for 50 cycles -> tx_valid stays 0, busy=0, ram_read_addr=0.
- RAM preloaded with byte = addr[7:0], start pulse, tx_ready=1 -> first bytes are B0/00/10 (dc=0), then 00,01,...,7F (dc=1); second page starts B1/00/10 then 80..FF. The frame totals 8*131 = 1048 bytes, with one frame_done pulse after the last byte (addr 1023 -> 8'hFF).
- COL_OFFSET=2 -> each page's column commands are 8'h02, 8'h10.
- tx_ready randomly low 50% of cycles -> tx_data and tx_dc are stable whenever tx_valid=1 and not accepted. The byte sequence is identical to the previous scenario.
- continuous=1 at frame end -> busy never drops, and 8'hB0 follows the last data byte immediately. Next, continuous=0 -> busy falls with frame_done, and a second start during busy has no effect.
- rst asserted in page 3 mid-data with tx_valid=1 -> next cycle tx_valid=0, busy=0. A new start restarts at 8'hB0 with address 0.
